// File: rtl/saturn_bus_fetch.sv
// Instruction-fetch controller for the nibble-wide HP48 bus: reloads the bus PC on jumps and streams PC_READ nibbles.
// Optional statistics counters are enabled by defining SATURN_BUS_FETCH_STATS_EN.
module saturn_bus_fetch #(
    parameter int          ADDR_W      = 20,
    parameter logic [3:0]  CMD_NOP     = 4'h0,
    parameter logic [3:0]  CMD_PC_READ = 4'h1,
    parameter logic [3:0]  CMD_LOAD_PC = 4'h4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_en_bus_send,
    input  logic              i_en_bus_recv,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic              i_stalled,
    output logic              o_bus_strobe,
    output logic [3:0]        o_bus_cmd,
    output logic [3:0]        o_bus_nibble_out,
    input  logic [3:0]        i_bus_nibble_in,
    output logic [3:0]        o_nibble,
    output logic              o_nibble_valid,
    output logic              o_fetch_stall
`ifdef SATURN_BUS_FETCH_STATS_EN
    ,
    output logic [31:0]       o_read_count,
    output logic [31:0]       o_reload_count
`endif
);

    localparam logic [2:0] LAST_IDX = 3'(ADDR_W / 4 - 1);

    typedef enum logic {S_LOAD, S_READ} state_t;

    state_t            state, state_d;
    logic [2:0]        load_idx, load_idx_d;
    logic [ADDR_W-1:0] load_addr, load_addr_d;
    logic [ADDR_W-1:0] r_addr, r_addr_d;
    logic [ADDR_W-1:0] addr_eff;
    logic              need_latch, need_latch_d;
    logic              rd_pending, rd_pending_d;
    logic              strobe_d, valid_d, stall_d;
    logic [3:0]        cmd_d, nib_out_d, nibble_d;

    always_comb begin
        state_d      = state;
        load_idx_d   = load_idx;
        load_addr_d  = load_addr;
        r_addr_d     = r_addr;
        need_latch_d = need_latch;
        rd_pending_d = rd_pending;
        strobe_d     = 1'b0;
        cmd_d        = CMD_NOP;
        nib_out_d    = 4'h0;
        nibble_d     = o_nibble;
        valid_d      = 1'b0;
        stall_d      = o_fetch_stall;
        addr_eff     = need_latch ? i_pc : load_addr;

        if (i_en_bus_send) begin
            case (state)
                S_LOAD: begin
                    // A fresh reload captures the core PC on its first slot; address goes out LSB nibble first
                    load_addr_d  = addr_eff;
                    need_latch_d = 1'b0;
                    strobe_d     = 1'b1;
                    cmd_d        = CMD_LOAD_PC;
                    nib_out_d    = addr_eff[4*load_idx +: 4];
                    if (load_idx == LAST_IDX) begin
                        r_addr_d   = addr_eff;
                        load_idx_d = 3'd0;
                        state_d    = S_READ;
                    end else begin
                        load_idx_d = load_idx + 3'd1;
                    end
                end
                S_READ: begin
                    if (i_pc != r_addr) begin
                        state_d      = S_LOAD;
                        need_latch_d = 1'b1;
                        load_idx_d   = 3'd0;
                        stall_d      = 1'b1;
                    end else if (!i_stalled) begin
                        strobe_d     = 1'b1;
                        cmd_d        = CMD_PC_READ;
                        rd_pending_d = 1'b1;
                    end
                end
                default: state_d = S_LOAD;
            endcase
        end else if (i_en_bus_recv && rd_pending) begin
            // The bus PC auto-increments on every read, so the local pointer follows it
            nibble_d     = i_bus_nibble_in;
            valid_d      = 1'b1;
            r_addr_d     = r_addr + 1'b1;
            stall_d      = 1'b0;
            rd_pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state            <= S_LOAD;
            load_idx         <= 3'd0;
            load_addr        <= '0;
            r_addr           <= '0;
            need_latch       <= 1'b1;
            rd_pending       <= 1'b0;
            o_bus_strobe     <= 1'b0;
            o_bus_cmd        <= CMD_NOP;
            o_bus_nibble_out <= 4'h0;
            o_nibble         <= 4'h0;
            o_nibble_valid   <= 1'b0;
            o_fetch_stall    <= 1'b1;
        end else begin
            state            <= state_d;
            load_idx         <= load_idx_d;
            load_addr        <= load_addr_d;
            r_addr           <= r_addr_d;
            need_latch       <= need_latch_d;
            rd_pending       <= rd_pending_d;
            o_bus_strobe     <= strobe_d;
            o_bus_cmd        <= cmd_d;
            o_bus_nibble_out <= nib_out_d;
            o_nibble         <= nibble_d;
            o_nibble_valid   <= valid_d;
            o_fetch_stall    <= stall_d;
        end
    end

`ifdef SATURN_BUS_FETCH_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic reload_start;
    assign reload_start = i_en_bus_send && (state == S_LOAD) && need_latch;

    // Each S_LOAD entry is counted on the slot that latches its target address
    always_ff @(posedge clk) begin
        if (!reset) begin
            o_read_count   <= 32'd0;
            o_reload_count <= 32'd0;
        end else begin
            if (strobe_d && (cmd_d == CMD_PC_READ))
                o_read_count <= sat_inc(o_read_count);
            if (reload_start) begin
                o_reload_count <= sat_inc(o_reload_count);
`ifdef SIM
                $display("BUS_FETCH LOAD_PC %05h", i_pc);
`endif
            end
        end
    end
`endif

endmodule

// File: tb/tb_saturn_bus_fetch.sv
// Scoreboard bench for saturn_bus_fetch with a behavioural nibble-bus slave.
// Define SATURN_BUS_FETCH_STATS_EN to also check the statistics counters.
module tb_saturn_bus_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en_send = 1'b0;
    logic        en_recv = 1'b0;
    logic [19:0] pc = 20'h0;
    logic        stalled = 1'b0;
    logic [3:0]  bus_in = 4'h0;
    logic        bus_strobe;
    logic [3:0]  bus_cmd;
    logic [3:0]  bus_nib_out;
    logic [3:0]  nibble;
    logic        nibble_valid;
    logic        fetch_stall;
`ifdef SATURN_BUS_FETCH_STATS_EN
    logic [31:0] read_count;
    logic [31:0] reload_count;
`endif

    saturn_bus_fetch dut (
        .clk              (clk),
        .reset            (reset),
        .i_en_bus_send    (en_send),
        .i_en_bus_recv    (en_recv),
        .i_pc             (pc),
        .i_stalled        (stalled),
        .o_bus_strobe     (bus_strobe),
        .o_bus_cmd        (bus_cmd),
        .o_bus_nibble_out (bus_nib_out),
        .i_bus_nibble_in  (bus_in),
        .o_nibble         (nibble),
        .o_nibble_valid   (nibble_valid),
        .o_fetch_stall    (fetch_stall)
`ifdef SATURN_BUS_FETCH_STATS_EN
        ,
        .o_read_count     (read_count),
        .o_reload_count   (reload_count)
`endif
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          exp_reads = 0;
    logic [3:0]  exp_q[$];
    logic [3:0]  mem [logic [19:0]];
    logic [19:0] model_pc = 20'h0;
    int          model_lpos = 0;
    logic        s_strobe;
    logic [3:0]  s_cmd;
    logic [3:0]  s_nib;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [3:0] mem_rd(input logic [19:0] a);
        if (mem.exists(a)) return mem[a];
        return a[3:0] ^ 4'h9;
    endfunction

    always @(negedge clk) begin
        if (reset && nibble_valid) begin
            if (exp_q.size() == 0) check("unexpected_valid", {31'b0, nibble_valid}, 32'd0);
            else check("nibble", {28'b0, nibble}, {28'b0, exp_q.pop_front()});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One bus cycle: send slot, recv slot, idle clk; the slave model answers strobes
    task automatic bus_cycle();
        en_send = 1'b1;
        tick();
        en_send = 1'b0;
        s_strobe = bus_strobe;
        s_cmd = bus_cmd;
        s_nib = bus_nib_out;
        if (s_strobe && s_cmd == 4'h4) begin
            model_pc[4*model_lpos +: 4] = s_nib;
            model_lpos = (model_lpos + 1) % 5;
        end
        if (s_strobe && s_cmd == 4'h1) begin
            bus_in = mem_rd(model_pc);
            model_pc = model_pc + 20'd1;
        end
        en_recv = 1'b1;
        tick();
        en_recv = 1'b0;
        tick();
    endtask

    task automatic do_load(input logic [19:0] addr, input int n);
        for (int i = 0; i < n; i++) begin
            bus_cycle();
            check("load_strobe", {31'b0, s_strobe}, 32'd1);
            check("load_cmd", {28'b0, s_cmd}, 32'h4);
            check("load_nib", {28'b0, s_nib}, {28'b0, addr[4*i +: 4]});
            check("load_stall", {31'b0, fetch_stall}, 32'd1);
        end
    endtask

    task automatic do_read(input logic [19:0] addr);
        pc = addr;
        exp_q.push_back(mem_rd(addr));
        exp_reads++;
        bus_cycle();
        check("read_strobe", {31'b0, s_strobe}, 32'd1);
        check("read_cmd", {28'b0, s_cmd}, 32'h1);
        check("read_stall", {31'b0, fetch_stall}, 32'd0);
        check("sb_drain", exp_q.size(), 32'd0);
    endtask

    task automatic detect(input logic [19:0] addr);
        pc = addr;
        bus_cycle();
        check("detect_strobe", {31'b0, s_strobe}, 32'd0);
        check("detect_stall", {31'b0, fetch_stall}, 32'd1);
    endtask

    task automatic check_reset_outputs();
        check("rst_strobe", {31'b0, bus_strobe}, 32'd0);
        check("rst_cmd", {28'b0, bus_cmd}, 32'd0);
        check("rst_nib_out", {28'b0, bus_nib_out}, 32'd0);
        check("rst_nibble", {28'b0, nibble}, 32'd0);
        check("rst_valid", {31'b0, nibble_valid}, 32'd0);
        check("rst_stall", {31'b0, fetch_stall}, 32'd1);
    endtask

    initial begin
        mem[20'h00000] = 4'h3;
        mem[20'h00001] = 4'h1;
        mem[20'h00002] = 4'h2;
        mem[20'h00003] = 4'h3;
        mem[20'h00004] = 4'h4;
        mem[20'h12345] = 4'h7;
        mem[20'h12346] = 4'hB;
        mem[20'hFFFFF] = 4'hA;
        mem[20'hABCDE] = 4'h5;

        for (int i = 0; i < 3; i++) tick();
        check_reset_outputs();
        reset = 1'b1;

        // Post-reset load of 00000 then first read
        do_load(20'h00000, 5);
        do_read(20'h00000);

        for (int a = 1; a <= 4; a++) do_read(20'(a));

        // Jump
        detect(20'h12345);
        do_load(20'h12345, 5);
        do_read(20'h12345);
`ifdef SATURN_BUS_FETCH_STATS_EN
        check("reload_count", reload_count, 32'd2);
        check("read_count", read_count, 32'(exp_reads));
`endif

        // Core stall holds the fetch
        pc = 20'h12346;
        stalled = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus_cycle();
            check("stall_strobe", {31'b0, s_strobe}, 32'd0);
            check("stall_hold", {28'b0, nibble}, {28'b0, mem_rd(20'h12345)});
        end
        stalled = 1'b0;
        do_read(20'h12346);

        // Address wrap
        detect(20'hFFFFF);
        do_load(20'hFFFFF, 5);
        do_read(20'hFFFFF);
        do_read(20'h00000);

        // Reset in the middle of a reload
        detect(20'hABCDE);
        do_load(20'hABCDE, 2);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check_reset_outputs();
        reset = 1'b1;
        model_lpos = 0;
        do_load(20'hABCDE, 5);
        do_read(20'hABCDE);

        repeat (4) tick();
        check("sb_leftover", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
